// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier with valid/ready handshakes on operands and product.
// Optional build macro SEQ_MUL_EARLY_EXIT_EN: when defined, RUN ends as soon as no multiplier bits remain.

module seq_shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;

  logic [PW-1:0]      sum;
  logic [PW:0]        carry;
  logic               unused_carry;
  logic               accept;
  logic               last_iter;

  // Ripple-carry acc + mcand; the final carry cannot be set for an unsigned WIDTH x WIDTH product.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < PW; i++) begin : g_adder
    fulladder u_fa (
      .a    (acc[i]),
      .b    (mcand[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign unused_carry = carry[PW];

  assign accept = in_valid & in_ready;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  // Once the remaining multiplier bits above bit 0 are clear, this iteration finishes the product.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so no input-to-output combinational path exists.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands are captured only on the accepting handshake, then iterated in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= sum;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// One-bit full adder cell used to build the ripple chain.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench for seq_shift_add_multiplier (WIDTH=16), with a back-to-back random sweep.
module tb_seq_shift_add_multiplier;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;

  int passed;
  int total;
  int edges;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Latency from accept edge to out_valid for a given multiplier value.
  function automatic int exp_latency(input logic [W-1:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp_p);
    int t0;
    out_ready = 1'b0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    wait_ready(tag);
    tick();
    t0 = edges;
    in_valid = 1'b0;
    wait_valid(tag);
    check({tag, "_lat"}, 64'(edges - t0), 64'(exp_latency(bv)));
    check({tag, "_prod"}, 64'(product), 64'(exp_p));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    check({tag, "_vld_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int t0;
    int prev_acc;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] rexp;

    passed = 0;
    total = 0;
    edges = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);

    // Directed vectors
    run_op("ffff_x_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("3_x_5", 16'd3, 16'd5, 32'd15);
    run_op("1234_x_0", 16'h1234, 16'h0000, 32'd0);
    run_op("0_x_abcd", 16'h0000, 16'hABCD, 32'd0);
    run_op("8000_x_2", 16'h8000, 16'h0002, 32'h0001_0000);

    // Backpressure: product holds while new operands wait at the input
    a = 16'd3;
    b = 16'd5;
    in_valid = 1'b1;
    wait_ready("bp_first");
    tick();
    a = 16'd7;
    b = 16'd9;
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) tick();
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_prod", 64'(product), 64'd15);
    check("bp_hold_inrdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_post_hs_rdy", 64'(in_ready), 64'd1);
    tick();
    t0 = edges;
    in_valid = 1'b0;
    check("bp_second_busy", 64'(in_ready), 64'd0);
    wait_valid("bp_second");
    check("bp_second_lat", 64'(edges - t0), 64'(exp_latency(16'd9)));
    check("bp_second_prod", 64'(product), 64'd63);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during RUN drops the operation
    a = 16'hABCD;
    b = 16'h1357;
    in_valid = 1'b1;
    wait_ready("mid_rst");
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_run_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_prod", 64'(product), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rdy", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    run_op("ff_x_101", 16'h00FF, 16'h0101, 32'h0000FFFF);

    // Back-to-back random operands with out_ready and in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    prev_acc = -1;
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      rexp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      a = ra;
      b = rb;
      wait_ready("rnd");
      tick();
      t0 = edges;
`ifndef SEQ_MUL_EARLY_EXIT_EN
      if (prev_acc >= 0) check("rnd_spacing", 64'(t0 - prev_acc), 64'(W + 2));
`endif
      prev_acc = t0;
      wait_valid("rnd");
      check("rnd_prod", 64'(product), 64'(rexp));
    end
    in_valid = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
